// File: rtl/gray_pkg.sv
// Shared constants and helpers for the pipelined Gray/binary converter.
package gray_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  // Gray-to-binary chunk size: the word is split MSB-first, the last chunk takes the remainder.
  function automatic int chunk_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline stage: resolves its Gray chunk (or does the whole binary-to-Gray
// conversion in stage 0) and holds the word in a valid/ready register slice.
import gray_pkg::*;

module gray_conv_stage #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_mode,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_mode
);

  localparam int CW = chunk_width(WIDTH, STAGES);
  localparam int HI = WIDTH - 1 - IDX * CW;
  localparam int LO = (HI - CW + 1 < 0) ? 0 : HI - CW + 1;

  logic [WIDTH-1:0] res;

  always_comb begin
    logic [WIDTH:0] r;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r   = {1'b0, up_data};
    res = up_data;
    if (up_mode == MODE_G2B) begin
      // r[HI+1] is the binary bit already resolved upstream (or 0 above the MSB).
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) r[i] = r[i+1] ^ up_data[i];
      end
      res = r[WIDTH-1:0];
    end else if (IDX == 0) begin
      res = up_data ^ (up_data >> 1);
    end
  end

  assign up_ready = (!dn_valid || dn_ready) && !sclr;

  // NOTE: data registers are reset as well so out_data reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_mode  <= 1'b0;
    end else if (sclr) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= res;
        dn_mode <= up_mode;
      end
    end
  end

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshake, flush and
// per-word mode; STAGES register slices chained via generate.
import gray_pkg::*;

module gray_conv_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             busy
);

  logic [STAGES:0]  v;
  logic [STAGES:0]  rdy;
  logic [STAGES:0]  m;
  logic [WIDTH-1:0] d [STAGES+1];
  logic             accept_en;

  // Holds in_ready low through reset and until the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) accept_en <= 1'b0;
    else        accept_en <= 1'b1;
  end

  assign v[0]        = in_valid && accept_en;
  assign d[0]        = in_data;
  assign m[0]        = in_mode;
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gray_conv_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclr     (sclr),
      .up_valid (v[k]),
      .up_ready (rdy[k]),
      .up_data  (d[k]),
      .up_mode  (m[k]),
      .dn_valid (v[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_data  (d[k+1]),
      .dn_mode  (m[k+1])
    );
  end

  assign in_ready  = rdy[0] && accept_en;
  assign out_valid = v[STAGES];
  assign out_data  = d[STAGES];
  assign out_mode  = m[STAGES];
  assign busy      = |v[STAGES:1];

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed bench for gray_conv_pipe: known vectors, streaming, stall, flush,
// reset and a parameter sweep with round-trip checks.
module tb_gray_conv_pipe;

  localparam int NCFG = 10;
  localparam int CFG_W [NCFG] = '{2, 7, 7, 7, 16, 16, 16, 64, 64, 64};
  localparam int CFG_S [NCFG] = '{1, 1, 3, 4, 1, 3, 4, 1, 3, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_mode;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_conv_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclr      (sclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .busy      (busy)
  );

  logic [NCFG-1:0] sw_valid = '0;
  logic [NCFG-1:0] sw_mode  = '0;
  logic [63:0]     sw_data [NCFG];
  wire  [NCFG-1:0] sw_iready;
  wire  [NCFG-1:0] sw_ovalid;
  wire  [NCFG-1:0] sw_omode;
  wire  [NCFG-1:0] sw_busy;
  wire  [63:0]     sw_out [NCFG];

  for (genvar c = 0; c < NCFG; c++) begin : g_sweep
    localparam int W = CFG_W[c];
    localparam int S = CFG_S[c];
    logic [W-1:0] od;
    gray_conv_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclr      (1'b0),
      .in_valid  (sw_valid[c]),
      .in_ready  (sw_iready[c]),
      .in_data   (sw_data[c][W-1:0]),
      .in_mode   (sw_mode[c]),
      .out_valid (sw_ovalid[c]),
      .out_ready (1'b1),
      .out_data  (od),
      .out_mode  (sw_omode[c]),
      .busy      (sw_busy[c])
    );
    assign sw_out[c] = 64'(od);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_w(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] g2b(input logic [63:0] g, input int w);
    logic [63:0] b = '0;
    b[w-1] = g[w-1];
    for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [63:0] b2g(input logic [63:0] b, input int w);
    logic [63:0] x = b & mask_w(w);
    return (x ^ (x >> 1)) & mask_w(w);
  endfunction

  // Single word on the 16/2 DUT with out_ready high; checks latency and result.
  task automatic send_one(input string tag, input logic [15:0] x, input logic md,
                          input logic [15:0] exp);
    int lat;
    @(negedge clk);
    in_data = x; in_mode = md; in_valid = 1'b1;
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1 lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    check({tag, "_mode"}, 64'(out_mode), 64'(md));
  endtask

  task automatic sw_send(input int c, input logic [63:0] x, input logic md,
                         output logic [63:0] y, output int lat, output logic om);
    @(negedge clk);
    sw_data[c] = x; sw_mode[c] = md; sw_valid[c] = 1'b1;
    #1;
    @(posedge clk);
    #1 sw_valid[c] = 1'b0;
    lat = 1;
    while (!sw_ovalid[c] && lat < 10) begin
      @(posedge clk); #1 lat++;
    end
    y  = sw_out[c];
    om = sw_omode[c];
  endtask

  initial begin
    logic [15:0] qd [$];
    logic        qm [$];
    logic [15:0] got [$];
    logic [15:0] sw_words [3];
    logic        sw_modes [3];
    logic [15:0] x;
    logic        md;
    int          cnt, idx;
    logic        acc;

    for (int c = 0; c < NCFG; c++) sw_data[c] = '0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed conversions
    send_one("g2b_8000", 16'h8000, 1'b0, 16'hFFFF);
    send_one("g2b_ffff", 16'hFFFF, 1'b0, 16'hAAAA);
    send_one("g2b_0000", 16'h0000, 1'b0, 16'h0000);
    send_one("b2g_ffff", 16'hFFFF, 1'b1, 16'h8000);
    send_one("b2g_00ff", 16'h00FF, 1'b1, 16'h0080);
    send_one("g2b_0001", 16'h0001, 1'b0, 16'h0001);
    @(negedge clk);
    @(negedge clk);

    // Back-to-back stream, alternating modes
    cnt = 0;
    for (int cyc = 0; cyc < 103; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (qd.size() > 0) begin
          check("stream_data", 64'(out_data), 64'(qd.pop_front()));
          check("stream_mode", 64'(out_mode), 64'(qm.pop_front()));
        end else begin
          check("stream_extra", 64'(out_valid), 64'd0);
        end
      end
      if (cyc >= 2 && cyc < 102) check("stream_tput", 64'(out_valid), 64'd1);
      if (cyc == 102) check("stream_tail", 64'(out_valid), 64'd0);
      if (cyc < 100) begin
        x  = 16'($urandom);
        md = cyc[0];
        in_data = x; in_mode = md; in_valid = 1'b1;
        qd.push_back(md ? 16'(b2g(64'(x), 16)) : 16'(g2b(64'(x), 16)));
        qm.push_back(md);
        #1 check("stream_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_count", 64'(cnt), 64'd100);

    // Stall with 3 words offered
    sw_words = '{16'h1234, 16'h00FF, 16'hFFFF};
    sw_modes = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (cyc == 5) out_ready = 1'b1;
      if (idx < 3) begin
        in_data = sw_words[idx]; in_mode = sw_modes[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (cyc == 4) begin
        check("stall_accepted", 64'(idx), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) got.push_back(out_data);
      else if (out_valid) begin
        check("stall_hold_data", 64'(out_data), g2b(64'h1234, 16));
        check("stall_hold_mode", 64'(out_mode), 64'd0);
      end
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stall_out_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check("stall_out0", 64'(got[0]), g2b(64'h1234, 16));
      check("stall_out1", 64'(got[1]), 64'h0080);
      check("stall_out2", 64'(got[2]), 64'hAAAA);
    end

    // Flush with 2 words in flight; the word offered with sclr is discarded
    out_ready = 1'b0;
    @(negedge clk); in_data = 16'h0F0F; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_data = 16'h3333; in_mode = 1'b1;
    @(negedge clk); sclr = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1 sclr = 1'b0; in_valid = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 check("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    @(negedge clk); in_data = 16'h1111; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk); in_data = 16'h2222; in_mode = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 check("mid_rst_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 check("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Parameter sweep: round trip through both modes, latency per configuration
    for (int c = 0; c < NCFG; c++) begin
      int          w, s, n, lat;
      logic [63:0] xv, y, z;
      logic        om;
      w = CFG_W[c];
      s = CFG_S[c];
      n = (w == 7) ? 128 : 24;
      for (int i = 0; i < n; i++) begin
        xv = (w == 7) ? 64'(i) : ({$urandom, $urandom} & mask_w(w));
        sw_send(c, xv, 1'b0, y, lat, om);
        check($sformatf("sw%0d_g2b_lat", c), 64'(lat), 64'(s));
        check($sformatf("sw%0d_g2b", c), y, g2b(xv, w));
        check($sformatf("sw%0d_g2b_mode", c), 64'(om), 64'd0);
        sw_send(c, y, 1'b1, z, lat, om);
        check($sformatf("sw%0d_b2g_lat", c), 64'(lat), 64'(s));
        check($sformatf("sw%0d_roundtrip", c), z, xv);
        check($sformatf("sw%0d_b2g_mode", c), 64'(om), 64'd1);
      end
      @(posedge clk); #1;
      check($sformatf("sw%0d_idle", c), 64'(sw_busy[c]), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
